// File: rtl/muldiv_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------------
// muldiv_unit : iterative RV32M multiply/divide; MULDIV_FAST_MUL_EN = 1-cycle multiply
// Rev 1.0
// ---------------------------------------------------------------------------------
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_addr,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_addr_out
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        state, state_next;
   logic [CW-1:0]     cnt;
   logic [2:0]        op;
   logic              neg_res, neg_rem;
   logic [XLEN-1:0]   mcand;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   rem;

   logic              accept;
   logic              a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic              div_zero, div_ovf, special;
   logic [XLEN-1:0]   special_res;

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next, prod_signed;
   logic [XLEN:0]     div_shift;
   logic [XLEN+1:0]   div_diff;
   logic              div_ge;
   logic [XLEN-1:0]   rem_next, quo_next, quo_signed, rem_signed;
   logic [2*XLEN-1:0] acc_next;
   logic [XLEN-1:0]   calc_res;

   assign accept = start && (state == S_IDLE || state == S_DONE);

   // Signedness of each operand by opcode: MUL/MULH/MULHSU/DIV/REM sign rs1, MUL/MULH/DIV/REM sign rs2
   assign a_signed = funct3[2] ? ~funct3[0] : (funct3 != 3'd3);
   assign b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
   assign a_neg    = a_signed & rs1_data[XLEN-1];
   assign b_neg    = b_signed & rs2_data[XLEN-1];
   assign a_mag    = a_neg ? (~rs1_data + 1'b1) : rs1_data;
   assign b_mag    = b_neg ? (~rs2_data + 1'b1) : rs2_data;

   assign div_zero = funct3[2] && (rs2_data == '0);
   assign div_ovf  = funct3[2] && ~funct3[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                     && (rs2_data == '1);

`ifdef MULDIV_FAST_MUL_EN
   logic signed [2*XLEN+1:0] fast_prod;
   logic [XLEN-1:0]          fast_res;
   assign fast_prod = $signed({a_neg, rs1_data}) * $signed({b_neg, rs2_data});
   assign fast_res  = (funct3 == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

   always_comb begin
      special     = 1'b0;
      special_res = '0;
      if (div_zero) begin
         special     = 1'b1;
         special_res = funct3[1] ? rs1_data : '1;
      end else if (div_ovf) begin
         special     = 1'b1;
         special_res = funct3[1] ? '0 : rs1_data;
      end
`ifdef MULDIV_FAST_MUL_EN
      else if (!funct3[2]) begin
         special     = 1'b1;
         special_res = fast_res;
      end
`endif
   end

   // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
   assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
   assign mul_next = {mul_sum, acc[XLEN-1:1]};

   // Divide: acc[XLEN-1:0] shifts dividend bits out and quotient bits in
   assign div_shift = {rem, acc[XLEN-1]};
   assign div_diff  = {1'b0, div_shift} - {2'b00, mcand};
   assign div_ge    = ~div_diff[XLEN+1];
   assign rem_next  = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
   assign quo_next  = {acc[XLEN-2:0], div_ge};

   assign acc_next    = op[2] ? {acc[2*XLEN-1:XLEN], quo_next} : mul_next;
   assign prod_signed = neg_res ? (~mul_next + 1'b1) : mul_next;
   assign quo_signed  = neg_res ? (~quo_next + 1'b1) : quo_next;
   assign rem_signed  = neg_rem ? (~rem_next + 1'b1) : rem_next;

   always_comb begin
      calc_res = '0;
      case (op)
         3'd0:             calc_res = prod_signed[XLEN-1:0];
         3'd1, 3'd2, 3'd3: calc_res = prod_signed[2*XLEN-1:XLEN];
         3'd4, 3'd5:       calc_res = quo_signed;
         default:          calc_res = rem_signed;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = special ? S_DONE : S_CALC;
         S_CALC:  if (cnt == LAST_STEP) state_next = S_DONE;
         S_DONE:  state_next = start ? (special ? S_DONE : S_CALC) : S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == S_CALC);
      done = (state == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt         <= '0;
         op          <= '0;
         neg_res     <= 1'b0;
         neg_rem     <= 1'b0;
         mcand       <= '0;
         acc         <= '0;
         rem         <= '0;
         result      <= '0;
         rd_addr_out <= '0;
      end else if (accept) begin
         cnt         <= '0;
         op          <= funct3;
         neg_res     <= a_neg ^ b_neg;
         neg_rem     <= a_neg;
         mcand       <= b_mag;
         acc         <= {{XLEN{1'b0}}, a_mag};
         rem         <= '0;
         rd_addr_out <= rd_addr;
         if (special) result <= special_res;
      end else if (state == S_CALC) begin
         cnt <= cnt + 1'b1;
         acc <= acc_next;
         rem <= rem_next;
         if (cnt == LAST_STEP) result <= calc_res;
      end
   end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit that executes the eight M-extension operations. It sits directly downstream of the register file: it consumes the two read-port operands and the destination index, and it returns a result plus a write-enable pulse to the register-file write port. The core stalls on `busy`. The unit performs one shift-add or shift-subtract step per clock, so a 32-bit operation occupies 32 calculation cycles.

## Interface
- `XLEN`, default 32: operand and result width; iteration count equals `XLEN`.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high reset, sampled on the `clk` rising edge.
- `start`  input  1  request; accepted only in IDLE or DONE.
- `funct3`  input  3  encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1_data`  input  XLEN  operand A (dividend), from register-file read port 1.
- `rs2_data`  input  XLEN  operand B (divisor), from register-file read port 2.
- `rd_addr`  input  5  destination register index.
- `busy`  output  1  operation in progress; core holds the next instruction.
- `done`  output  1  one-cycle pulse; drives the register-file write enable.
- `result`  output  XLEN  write data; valid while `done` is high and held until the next accept.
- `rd_addr_out`  output  5  destination index latched at accept.

## Operation
- States:
  - IDLE: `start` moves to CALC, or directly to DONE on a special case.
  - CALC: 5-bit step counter runs from 0 to 31; after step 31, move to DONE.
  - DONE: `start` moves to CALC or DONE; otherwise move to IDLE.
- Accept:
  - On accept, latch `funct3`, `rd_addr` and both operands; later changes on the inputs have no effect.
  - `start` is ignored while in CALC.
- Signed handling:
  - Operands are converted to magnitudes and processed unsigned.
  - Signs: MUL/MULH use both operands; MULHSU uses only `rs1_data`; MULHU, DIVU and REMU are unsigned.
  - Product and quotient are negated when the operand signs differ. The remainder takes the sign of the dividend.
- Multiply: 2·XLEN accumulator, shift-add, one bit per cycle. MUL returns the low half; MULH, MULHSU and MULHU return the high half.
- Divide: restoring division, one quotient bit per cycle, with an (XLEN+1)-bit partial remainder.
- Special cases go directly to DONE, giving a 1-cycle latency:
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
  - DIV of 0x80000000 by 0xFFFFFFFF returns 0x80000000; the matching REM returns 0.
- The x0 destination is not special-cased here; the register-file write path handles it.

## Timing
- Reset state: IDLE, `busy`=0, `done`=0, `result`=0, `rd_addr_out`=0, counter=0.
- For start sampled at the end of cycle 0, normal path:
  - Cycles 1–32: CALC, `busy`=1.
  - Cycle 33: DONE, `busy`=0, `done`=1, `result` valid.
- Special-case path: `done`=1 in cycle 1, `busy`=0 throughout.
- Back-to-back:
  - `start` high in the DONE cycle is accepted; the new operation's cycle 0 is that DONE cycle.
  - `done` drops the next cycle unless that next operation is itself special and also completes in one cycle.
- Reset asserted during CALC or DONE:
  - Abort the operation.
  - The next cycle shows IDLE with all outputs zero; no `done` pulse is produced.
- `start` and `reset` asserted together: reset wins and nothing is accepted.
- `result` and `rd_addr_out` do not change between `done` and the next accept.

## Configuration
- `MULDIV_FAST_MUL_EN`:
  - Defined: funct3 0–3 use a single-cycle combinational 33×33 signed multiply. Accept goes directly to DONE, so `done` is high in cycle 1 and `busy` stays 0.
  - Undefined: multiply is iterative (33-cycle latency) as above. Division is iterative in both builds.

## Test plan
- Sign handling:
  - MUL 7 × 0xFFFFFFFD gives `result`=0xFFFFFFEB with `done` in cycle 33 (cycle 1 when fast).
  - The same operands give MULH 0xFFFFFFFF, MULHU 0x00000006, MULHSU 0x00000006.
- Signed divide: DIV 0xFFFFFFF9 / 2 gives 0xFFFFFFFD in cycle 33; REM gives 0xFFFFFFFF; DIVU 100 / 7 gives 14 and REMU gives 2.
- Special cases, all with `done` in cycle 1:
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM gives 0.
  - DIVU 5 / 0 gives 0xFFFFFFFF; REM 5 / 0 gives 5.
- Operand isolation: toggle `start` and change operands during CALC; `result` reflects only the first operation and `rd_addr_out` equals the latched `rd_addr`.
- Back-to-back: assert `start` in the DONE cycle with REMU 9 / 4; the second `done` comes 33 cycles later with `result`=1 and no gap cycle in IDLE.
- Reset in cycle 10 of a DIV: IDLE next cycle, all outputs 0, no `done` within 40 cycles. A fresh MUL 3 × 5 then returns 15.
